// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD ALU: stage 1 captures opcode and operands, stage 2 holds the
// per-lane results, predicates and reserved-opcode flag behind a valid/ready handshake.
`timescale 1ns/1ps

module simd_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             ALU_C,
  input  logic [LANES*WIDTH-1:0] A,
  input  logic [LANES*WIDTH-1:0] B,
  input  logic [LANES*WIDTH-1:0] C,
  output logic [LANES*WIDTH-1:0] ALU_OUT,
  output logic [LANES-1:0]       P,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_CLR   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_MAD   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_MAX   = 4'd10,
    OP_MIN   = 4'd11,
    OP_ACC   = 4'd12,
    OP_ACCLR = 4'd13
  } alu_op_e;

  logic                   stall_s;
  logic                   advance_s;
  logic                   accept_s;
  logic                   s1_fire_s;
  logic                   err_s;
  logic [LANES*WIDTH-1:0] res_s;
  logic [LANES-1:0]       pred_s;

  logic                   s1_valid_r;
  logic [3:0]             s1_op_r;
  logic [LANES*WIDTH-1:0] s1_a_r;
  logic [LANES*WIDTH-1:0] s1_b_r;
  logic [LANES*WIDTH-1:0] s1_c_r;

  logic                   out_valid_r;
  logic [LANES*WIDTH-1:0] alu_out_r;
  logic [LANES-1:0]       p_r;
  logic                   err_r;

  // Handshake: a held result freezes both stages together.
  always_comb begin
    stall_s   = out_valid_r && !out_ready;
    advance_s = !stall_s;
    accept_s  = in_valid && advance_s;
    s1_fire_s = s1_valid_r && advance_s;
  end

  assign in_ready  = advance_s;
  assign out_valid = out_valid_r;
  assign ALU_OUT   = alu_out_r;
  assign P         = p_r;
  assign err       = err_r;

  // Reserved-opcode detection for the operation sitting in stage 1.
  always_comb begin
    err_s = 1'b0;
    case (s1_op_r)
      4'd14, 4'd15: err_s = 1'b1;
      default:      err_s = 1'b0;
    endcase
  end

  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] res_lane_s;
    logic [WIDTH-1:0] acc_r;

    assign a_s = s1_a_r[lane*WIDTH +: WIDTH];
    assign b_s = s1_b_r[lane*WIDTH +: WIDTH];
    assign c_s = s1_c_r[lane*WIDTH +: WIDTH];

    // Per-lane opcode decode; ACC reads the live accumulator so back-to-back ACCs chain.
    always_comb begin
      prod_s     = a_s * b_s;
      res_lane_s = {WIDTH{1'b0}};
      case (s1_op_r)
        OP_CLR:   res_lane_s = {WIDTH{1'b0}};
        OP_ADD:   res_lane_s = a_s + b_s;
        OP_SUB:   res_lane_s = a_s - b_s;
        OP_MUL:   res_lane_s = prod_s;
        OP_MAD:   res_lane_s = prod_s + c_s;
        OP_AND:   res_lane_s = a_s & b_s;
        OP_OR:    res_lane_s = a_s | b_s;
        OP_XOR:   res_lane_s = a_s ^ b_s;
        OP_SHL:   res_lane_s = a_s << b_s[SHW-1:0];
        OP_SHR:   res_lane_s = a_s >> b_s[SHW-1:0];
        OP_MAX:   res_lane_s = ($signed(a_s) > $signed(b_s)) ? a_s : b_s;
        OP_MIN:   res_lane_s = ($signed(a_s) < $signed(b_s)) ? a_s : b_s;
        OP_ACC:   res_lane_s = acc_r + prod_s;
        OP_ACCLR: res_lane_s = c_s;
        default:  res_lane_s = {WIDTH{1'b0}};
      endcase
    end

    assign res_s[lane*WIDTH +: WIDTH] = res_lane_s;
    assign pred_s[lane] = !res_lane_s[WIDTH-1] && (res_lane_s != {WIDTH{1'b0}});

    // Accumulator commits only when its operation leaves stage 1.
    always_ff @(posedge clock) begin
      if (reset) begin
        acc_r <= {WIDTH{1'b0}};
      end else if (s1_fire_s && ((s1_op_r == OP_ACC) || (s1_op_r == OP_ACCLR))) begin
        acc_r <= res_lane_s;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  // Stage 1: operand and opcode capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 4'd0;
      s1_a_r     <= {(LANES*WIDTH){1'b0}};
      s1_b_r     <= {(LANES*WIDTH){1'b0}};
      s1_c_r     <= {(LANES*WIDTH){1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= ALU_C;
      s1_a_r     <= A;
      s1_b_r     <= B;
      s1_c_r     <= C;
    end else if (advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: result register, held untouched while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      alu_out_r   <= {(LANES*WIDTH){1'b0}};
      p_r         <= {LANES{1'b0}};
      err_r       <= 1'b0;
    end else if (s1_fire_s) begin
      out_valid_r <= 1'b1;
      alu_out_r   <= res_s;
      p_r         <= pred_s;
      err_r       <= err_s;
    end else if (advance_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed self-checking bench for simd_alu_pipe (WIDTH=16, LANES=4) with an
// in-order scoreboard fed at acceptance and drained at the output handshake.
`timescale 1ns/1ps

module tb_simd_alu_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALU_C;
  logic [63:0] A;
  logic [63:0] B;
  logic [63:0] C;
  logic [63:0] ALU_OUT;
  logic [3:0]  P;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  simd_alu_pipe #(.WIDTH(16), .LANES(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALU_C    (ALU_C),
    .A        (A),
    .B        (B),
    .C        (C),
    .ALU_OUT  (ALU_OUT),
    .P        (P),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  typedef struct {
    logic [63:0] res;
    logic [3:0]  p;
    logic        err;
    int          cyc;
    bit          lat;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used for the latency check.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor: compare every consumed result against the scoreboard head.
  always @(negedge clock) begin
    sb_t e;
    if (reset) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("alu_out", ALU_OUT, e.res);
        check("pred", {60'd0, P}, {60'd0, e.p});
        check("err", {63'd0, err}, {63'd0, e.err});
        if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  // Present one operation on one lane (other lanes zero) and wait until accepted.
  task automatic issue(input logic [3:0] op, input int lane, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c, input logic [15:0] r,
                       input logic p, input logic e, input bit lat);
    sb_t item;
    bit  done;
    A = 64'd0; B = 64'd0; C = 64'd0;
    A[lane*16 +: 16] = a;
    B[lane*16 +: 16] = b;
    C[lane*16 +: 16] = c;
    ALU_C    = op;
    in_valid = 1'b1;
    item.res = 64'd0;
    item.res[lane*16 +: 16] = r;
    item.p   = 4'd0;
    item.p[lane] = p;
    item.err = e;
    item.lat = lat;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clock);
      if (in_ready) begin
        item.cyc = cyc;
        sb.push_back(item);
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(negedge clock);
      #1;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  logic [15:0] basic_exp [10] = '{16'd0, 16'd27, 16'd23, 16'd50, 16'd55,
                                  16'd0, 16'd27, 16'd27, 16'd100, 16'd6};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; ALU_C = 4'd1; A = 64'd1; B = 64'd1; C = 64'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_alu_out", ALU_OUT, 64'd0);
    check("rst_p", {60'd0, P}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clock);
    check("no_accept_in_rst", {63'd0, out_valid}, 64'd0);
    @(posedge clock);
    #1;

    // Basic opcodes, back to back on lane 0.
    for (int op = 0; op < 10; op++)
      issue(4'(op), 0, 16'd25, 16'd2, 16'd5, basic_exp[op],
            (op != 0 && op != 5), 1'b0, 1'b1);
    drain();

    // Signed ops and wrap-around on lane 1.
    issue(4'd10, 1, 16'hFFFF, 16'h0001, 16'd0, 16'h0001, 1'b1, 1'b0, 1'b1);
    issue(4'd11, 1, 16'hFFFF, 16'h0001, 16'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    issue(4'd1,  1, 16'hFFFF, 16'h0001, 16'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    issue(4'd1,  1, 16'h7FFF, 16'h0001, 16'd0, 16'h8000, 1'b0, 1'b0, 1'b1);
    issue(4'd2,  1, 16'h0000, 16'h0001, 16'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    drain();

    // Accumulator chain without bubbles.
    issue(4'd13, 0, 16'd0, 16'd0, 16'd10, 16'd10, 1'b1, 1'b0, 1'b1);
    issue(4'd12, 0, 16'd3, 16'd4, 16'd0, 16'd22, 1'b1, 1'b0, 1'b1);
    issue(4'd12, 0, 16'd3, 16'd4, 16'd0, 16'd34, 1'b1, 1'b0, 1'b1);
    issue(4'd12, 0, 16'd3, 16'd4, 16'd0, 16'd46, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure: two ops fill the pipe, the third waits for out_ready.
    out_ready = 1'b0;
    issue(4'd1, 2, 16'd1, 16'd10, 16'd0, 16'd11, 1'b1, 1'b0, 1'b0);
    issue(4'd1, 2, 16'd2, 16'd10, 16'd0, 16'd12, 1'b1, 1'b0, 1'b0);
    fork
      issue(4'd1, 2, 16'd3, 16'd10, 16'd0, 16'd13, 1'b1, 1'b0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clock);
          #1;
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
          check("stall_out_valid", {63'd0, out_valid}, 64'd1);
          check("stall_hold", ALU_OUT, 64'd11 << 32);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    issue(4'd1, 2, 16'd4, 16'd10, 16'd0, 16'd14, 1'b1, 1'b0, 1'b0);
    drain();

    // Reserved opcodes.
    issue(4'd15, 0, 16'd25, 16'd2, 16'd5, 16'd0, 1'b0, 1'b1, 1'b1);
    issue(4'd14, 3, 16'd25, 16'd2, 16'd5, 16'd0, 1'b0, 1'b1, 1'b1);
    drain();

    // Reset with two ACCs in flight: both discarded, accumulator cleared.
    issue(4'd12, 0, 16'd3, 16'd4, 16'd0, 16'd58, 1'b1, 1'b0, 1'b1);
    issue(4'd12, 0, 16'd3, 16'd4, 16'd0, 16'd70, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_alu_out", ALU_OUT, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(negedge clock);
    check("midrst_no_stale", {63'd0, out_valid}, 64'd0);
    @(posedge clock);
    #1;
    issue(4'd12, 0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    issue(4'd12, 0, 16'd3, 16'd4, 16'd0, 16'd12, 1'b1, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
